// File: rtl/hp_detect_if.sv
// rtl/hp_detect_if.sv - audio input and measured half-period outputs of hp_detect
interface hp_detect_if;
  logic       audio_in;
  logic [6:0] hp;
  logic       hp_valid;
  logic       hp_update;
  logic       tone_present;

  modport master (
    output audio_in,
    input  hp,
    input  hp_valid,
    input  hp_update,
    input  tone_present
  );

  modport slave (
    input  audio_in,
    output hp,
    output hp_valid,
    output hp_update,
    output tone_present
  );
endinterface

// File: rtl/hp_detect.sv
// rtl/hp_detect.sv - square-wave half-period detector with lock and timeout
module hp_detect #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 2,
  parameter int TOL         = 0
) (
  input  logic        synth_clk,
  input  logic        rst,
  hp_detect_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_COUNT);
  localparam logic [7:0] TOL_8    = 8'(TOL);

  state_t     state;
  logic [6:0] cnt;
  logic [6:0] cand;
  logic [2:0] match_cnt;
  logic       prev;
  logic [6:0] hp_q;
  logic       hp_valid_q;
  logic       hp_update_q;
  logic       tone_present_q;

  logic       s;
  logic       tone_edge;
  logic       timeout;
  logic [7:0] d_cand;
  logic [7:0] d_hp;
  logic [2:0] match_new;

  // Differences are taken at 8 bits so 1-127 never wraps.
  function automatic logic [7:0] absdiff(input logic [6:0] a, input logic [6:0] b);
    logic [7:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[7] ? (8'd0 - d) : d;
  endfunction

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = bus.audio_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge synth_clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.audio_in};
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign tone_edge = (s != prev);
  assign timeout   = (cnt == 7'd127) && !tone_edge;
  assign d_cand    = absdiff(cnt, cand);
  assign d_hp      = absdiff(cnt, hp_q);
  assign match_new = ((match_cnt == 3'd0) || (d_cand > TOL_8)) ? 3'd1 : match_cnt + 3'd1;

  always_ff @(posedge synth_clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      cand           <= '0;
      match_cnt      <= '0;
      prev           <= 1'b0;
      hp_q           <= '0;
      hp_valid_q     <= 1'b0;
      hp_update_q    <= 1'b0;
      tone_present_q <= 1'b0;
    end else begin
      prev        <= s;
      hp_update_q <= 1'b0;

      if (tone_edge)                          cnt <= 7'd1;
      else if (state == IDLE || timeout)      cnt <= 7'd0;
      else if (cnt != 7'd127)                 cnt <= cnt + 7'd1;

      case (state)
        IDLE: begin
          // The first edge only starts the interval counter.
          if (tone_edge) begin
            state          <= ACQ;
            tone_present_q <= 1'b1;
          end
        end
        ACQ: begin
          if (tone_edge) begin
            cand      <= cnt;
            match_cnt <= match_new;
            if (match_new == LOCK_CNT) begin
              state       <= LOCK;
              hp_q        <= cnt;
              hp_valid_q  <= 1'b1;
              hp_update_q <= 1'b1;
            end
          end
        end
        LOCK: begin
          if (tone_edge) begin
            if (d_hp <= TOL_8) begin
              hp_q        <= cnt;
              hp_update_q <= (cnt != hp_q);
            end else begin
              state      <= ACQ;
              hp_q       <= '0;
              hp_valid_q <= 1'b0;
              cand       <= cnt;
              match_cnt  <= 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A timeout never coincides with an edge, so it cleanly overrides the case above.
      if (timeout) begin
        state          <= IDLE;
        hp_q           <= '0;
        hp_valid_q     <= 1'b0;
        tone_present_q <= 1'b0;
        match_cnt      <= '0;
        cand           <= '0;
      end
    end
  end

  assign bus.hp           = hp_q;
  assign bus.hp_valid     = hp_valid_q;
  assign bus.hp_update    = hp_update_q;
  assign bus.tone_present = tone_present_q;

endmodule

// File: tb/tb_hp_detect.sv
// tb/tb_hp_detect.sv - scoreboard bench for hp_detect (unsynchronised and 2-stage variants)
module tb_hp_detect;

  typedef struct {
    logic [6:0] hp;
    int         cyc;
  } exp_t;

  logic synth_clk;
  logic rst;
  int   cyc;
  int   nchk;
  int   nerr;
  exp_t q_a[$];
  exp_t q_b[$];

  hp_detect_if a ();
  hp_detect_if b ();

  hp_detect #(.SYNC_STAGES(0), .LOCK_COUNT(2), .TOL(0)) dut_a (
    .synth_clk (synth_clk),
    .rst       (rst),
    .bus       (a)
  );

  hp_detect #(.SYNC_STAGES(2), .LOCK_COUNT(2), .TOL(1)) dut_b (
    .synth_clk (synth_clk),
    .rst       (rst),
    .bus       (b)
  );

  initial begin
    synth_clk = 1'b0;
    forever #5 synth_clk = ~synth_clk;
  end

  always @(posedge synth_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge synth_clk);
  endtask

  task automatic flip(input int which);
    if (which == 0) a.audio_in = ~a.audio_in;
    else            b.audio_in = ~b.audio_in;
  endtask

  // Expected hp_update: value and the negedge-sampled cycle at which it must appear.
  task automatic push(input int which, input int v, input int lat);
    exp_t e;
    e.hp  = 7'(v);
    e.cyc = cyc + lat;
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
  endtask

  always @(negedge synth_clk) begin
    if (!rst && a.hp_update) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_update_hp", int'(a.hp), -1);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_upd_hp", int'(a.hp), int'(e.hp));
        chk("a_upd_cycle", cyc, e.cyc);
        chk("a_upd_valid", int'(a.hp_valid), 1);
      end
    end
  end

  always @(negedge synth_clk) begin
    if (!rst && b.hp_update) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_update_hp", int'(b.hp), -1);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_upd_hp", int'(b.hp), int'(e.hp));
        chk("b_upd_cycle", cyc, e.cyc);
        chk("b_upd_valid", int'(b.hp_valid), 1);
      end
    end
  end

  initial begin
    cyc = 0;
    nchk = 0;
    nerr = 0;
    rst = 1'b1;
    a.audio_in = 1'b0;
    b.audio_in = 1'b0;
    wait_cyc(3);
    chk("a_rst_hp", int'(a.hp), 0);
    chk("a_rst_valid", int'(a.hp_valid), 0);
    chk("a_rst_update", int'(a.hp_update), 0);
    chk("a_rst_tone", int'(a.tone_present), 0);
    chk("b_rst_hp", int'(b.hp), 0);
    chk("b_rst_tone", int'(b.tone_present), 0);
    rst = 1'b0;

    // Unsynchronised instance: lock at 5, retune to 9, 20, then timeout.
    wait_cyc(2); flip(0);
    wait_cyc(5);
    chk("a_acq_tone", int'(a.tone_present), 1);
    chk("a_acq_valid", int'(a.hp_valid), 0);
    flip(0);
    wait_cyc(5); flip(0); push(0, 5, 1);
    wait_cyc(5);
    chk("a_lock5_valid", int'(a.hp_valid), 1);
    chk("a_lock5_hp", int'(a.hp), 5);
    flip(0);
    wait_cyc(5); flip(0);
    wait_cyc(9); flip(0);
    wait_cyc(2);
    chk("a_unlock9_valid", int'(a.hp_valid), 0);
    chk("a_unlock9_hp", int'(a.hp), 0);
    chk("a_unlock9_tone", int'(a.tone_present), 1);
    wait_cyc(7); flip(0); push(0, 9, 1);
    wait_cyc(9);
    chk("a_lock9_hp", int'(a.hp), 9);
    flip(0);
    wait_cyc(20); flip(0);
    wait_cyc(20); flip(0); push(0, 20, 1);
    wait_cyc(127);
    chk("a_pre_timeout_valid", int'(a.hp_valid), 1);
    chk("a_pre_timeout_hp", int'(a.hp), 20);
    wait_cyc(1);
    chk("a_timeout_valid", int'(a.hp_valid), 0);
    chk("a_timeout_hp", int'(a.hp), 0);
    chk("a_timeout_tone", int'(a.tone_present), 0);
    flip(0);
    wait_cyc(1);
    chk("a_retone_tone", int'(a.tone_present), 1);
    chk("a_retone_valid", int'(a.hp_valid), 0);

    // Boundaries: hp=1, hp=127, spacing 128.
    flip(0);
    wait_cyc(1); flip(0); push(0, 1, 1);
    wait_cyc(3);
    chk("a_lock1_valid", int'(a.hp_valid), 1);
    chk("a_lock1_hp", int'(a.hp), 1);
    wait_cyc(124); flip(0);
    wait_cyc(127); flip(0); push(0, 127, 1);
    wait_cyc(127);
    chk("a_lock127_valid", int'(a.hp_valid), 1);
    chk("a_lock127_hp", int'(a.hp), 127);
    flip(0);
    wait_cyc(128);
    chk("a_gap128_valid", int'(a.hp_valid), 0);
    chk("a_gap128_tone", int'(a.tone_present), 0);
    flip(0);
    wait_cyc(128);
    chk("a_gap128b_tone", int'(a.tone_present), 0);
    flip(0);
    wait_cyc(128);
    chk("a_gap128c_valid", int'(a.hp_valid), 0);
    chk("a_gap128c_tone", int'(a.tone_present), 0);

    // Two-stage synchroniser, TOL=1: tracking within tolerance.
    wait_cyc(2); flip(1);
    wait_cyc(10); flip(1);
    wait_cyc(10); flip(1); push(1, 10, 3);
    wait_cyc(10);
    chk("b_lock10_valid", int'(b.hp_valid), 1);
    chk("b_lock10_hp", int'(b.hp), 10);
    flip(1);
    wait_cyc(11); flip(1); push(1, 11, 3);
    wait_cyc(10); flip(1); push(1, 10, 3);
    wait_cyc(10); flip(1);
    wait_cyc(13); flip(1);
    wait_cyc(4);
    chk("b_unlock13_valid", int'(b.hp_valid), 0);
    chk("b_unlock13_hp", int'(b.hp), 0);
    chk("b_unlock13_tone", int'(b.tone_present), 1);

    // Reset mid-acquisition.
    rst = 1'b1;
    a.audio_in = 1'b0;
    b.audio_in = 1'b0;
    wait_cyc(1);
    chk("b_midrst_hp", int'(b.hp), 0);
    chk("b_midrst_valid", int'(b.hp_valid), 0);
    chk("b_midrst_update", int'(b.hp_update), 0);
    chk("b_midrst_tone", int'(b.tone_present), 0);
    rst = 1'b0;

    wait_cyc(2); flip(1);
    wait_cyc(7); flip(1);
    wait_cyc(7); flip(1); push(1, 7, 3);
    wait_cyc(10);
    chk("b_lock7_valid", int'(b.hp_valid), 1);
    chk("b_lock7_hp", int'(b.hp), 7);

    wait_cyc(5);
    chk("a_pending_updates", q_a.size(), 0);
    chk("b_pending_updates", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
